// File: rtl/fp_round_pkg.sv
// fp_round_pkg: shared definitions for the floating-point rounding unit.
//   - rm_e      : rounding-mode encodings carried on in_mode
//   - EXP_W_DEF : default exponent width
//   - MAN_W_DEF : default stored-fraction width
//   - any_set   : helper that reports whether any guard/round/sticky bit is set
package fp_round_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RUP = 3'b010,
    RM_RDN = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  function automatic logic any_set(input logic g, input logic r, input logic s);
    return g | r | s;
  endfunction

endpackage

// File: rtl/fp_round_incr.sv
// fp_round_incr: combinational round-increment decision.
//   mode : rounding mode (rm_e encoding, unknown codes fall back to RNE)
//   sign : operand sign
//   lsb  : least significant kept fraction bit
//   g,r,s: guard, round and sticky bits
//   inc  : 1 when the kept significand must be incremented
// Build option: FP_ROUND_RMM_EN enables round-to-nearest-max-magnitude on
// mode 100; without it that code decodes as RNE and no RMM logic exists.
module fp_round_incr
  import fp_round_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  output logic       inc
);

  always_comb begin
    // RNE is the default so that reserved codes round to nearest-even.
    inc = g & (r | s | lsb);
    case (mode)
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = !sign && any_set(g, r, s);
      RM_RDN: inc = sign && any_set(g, r, s);
`ifdef FP_ROUND_RMM_EN
      RM_RMM: inc = g;
`else
      RM_RMM: inc = g & (r | s | lsb);
`endif
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fp_round_unit.sv
// fp_round_unit: two-stage pipelined rounder for a normalised significand.
//   clk, rst      : clock and synchronous active-high reset
//   in_valid/ready: input beat handshake
//   in_sign       : operand sign (passed through)
//   in_exp        : biased normalised exponent (all ones = Inf/NaN)
//   in_mant       : {hidden, fraction[MAN_W], G, R, S}
//   in_mode       : rounding mode (fp_round_pkg::rm_e)
//   out_valid/ready: output beat handshake
//   out_sign, out_exp, out_frac : rounded result
//   out_inexact, out_overflow   : exception flags
// Build option: FP_ROUND_RMM_EN (see fp_round_incr) enables RMM on mode 100.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. valid never depends on ready; while a beat is
// offered but not taken, out_valid stays high and the out_* payload is held.
//
// Stage 1 decides the increment and forms the incremented significand.
// Stage 2 renormalises on carry-out, bumps the exponent and forms the flags.
module fp_round_unit
  import fp_round_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+3:0] in_mant,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_frac,
  output logic             out_inexact,
  output logic             out_overflow
);

  // Significand plus one carry bit: {carry, hidden, fraction}.
  localparam int SIG_W = MAN_W + 2;

  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  // Stage-1 input decode
  logic [MAN_W:0]   in_sig;
  logic             in_g;
  logic             in_r;
  logic             in_s;
  logic             in_special;
  logic             raw_inc;
  logic             in_inc;
  logic [SIG_W-1:0] in_sum;

  // Stage-1 registers
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_sum;
  logic             s1_lost;
  logic             s1_special;

  // Stage-2 combinational result
  logic             carry;
  logic [EXP_W-1:0] rnd_exp;
  logic [MAN_W-1:0] rnd_frac;
  logic             ovf;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && s2_adv;
  assign out_valid = s2_valid;

  assign in_sig     = in_mant[MAN_W+3:3];
  assign in_g       = in_mant[2];
  assign in_r       = in_mant[1];
  assign in_s       = in_mant[0];
  assign in_special = &in_exp;

  fp_round_incr u_incr (
    .mode (in_mode),
    .sign (in_sign),
    .lsb  (in_mant[3]),
    .g    (in_g),
    .r    (in_r),
    .s    (in_s),
    .inc  (raw_inc)
  );

  // Inf/NaN operands are never rounded.
  assign in_inc = raw_inc && !in_special;
  assign in_sum = {1'b0, in_sig} + SIG_W'(in_inc);

  // A carry-out means the significand became 10.000..., so drop one bit.
  // Special operands never carry because their increment is suppressed.
  assign carry    = s1_sum[SIG_W-1];
  assign rnd_exp  = carry ? (s1_exp + EXP_W'(1)) : s1_exp;
  assign rnd_frac = carry ? s1_sum[MAN_W:1] : s1_sum[MAN_W-1:0];
  assign ovf      = !s1_special && (&rnd_exp);

  // Valid bits and output registers: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_frac     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv)   s2_valid <= s1_valid;
      if (s2_load) begin
        out_sign     <= s1_sign;
        out_exp      <= rnd_exp;
        out_frac     <= ovf ? '0 : rnd_frac;
        out_inexact  <= s1_lost | ovf;
        out_overflow <= ovf;
      end
    end
  end

  // Stage-1 payload: only meaningful while s1_valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sign    <= in_sign;
      s1_exp     <= in_exp;
      s1_sum     <= in_sum;
      s1_lost    <= !in_special && any_set(in_g, in_r, in_s);
      s1_special <= in_special;
    end
  end

endmodule
